trig_arbiter: RTL
=================

Name: trig_arbiter

Overview:
- Shares a single sin_cos lookup instance between up to NUM_REQ requesters: ship heading, bullet launch vectors, asteroid spawn directions.
- Uses round-robin arbitration with one lookup issued per cycle.
- Tags each issued lookup through a pipeline that matches the LUT latency.
- Captures each requester's result into its own holding register and pulses a per-requester done strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PHASE_W, 10, phase width (1024 steps per turn).
- VAL_W, 18, signed sin/cos width.
- LUT_LAT, 1, clock cycles from lut_phase being sampled to lut_sin/lut_cos being valid.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- phase  in  NUM_REQ*PHASE_W  packed phases; requester i occupies bits [i*PHASE_W +: PHASE_W].
- gnt  out  NUM_REQ  one-hot grant, combinational, valid in the cycle the request is accepted.
- lut_phase  out  PHASE_W  registered phase to the sin_cos instance.
- lut_sin  in  VAL_W  signed sine from sin_cos.
- lut_cos  in  VAL_W  signed cosine from sin_cos.
- sin_out  out  NUM_REQ*VAL_W  per-requester held sine result.
- cos_out  out  NUM_REQ*VAL_W  per-requester held cosine result.
- done  out  NUM_REQ  one-cycle pulse: the matching sin_out/cos_out slice updated this cycle.
- idle  out  1  high when no lookup is in flight and req==0.

Behaviour:
- Reset (synchronous, active-high) sets:
  - gnt=0, done=0, lut_phase=0, all sin_out/cos_out=0, rr pointer=0, tag pipeline cleared, idle=1.
- Arbitration, cycle t:
  - Search req starting at index rr, ascending with wrap modulo NUM_REQ; the first set bit w wins.
  - gnt[w]=1 combinationally; at most one gnt bit is high per cycle.
  - If there is no request: gnt=0, rr unchanged, lut_phase holds its value, no tag is issued.
- On grant, at the edge ending cycle t:
  - lut_phase <= phase[w].
  - rr <= (w+1) mod NUM_REQ.
  - Tag stage 0 <= {valid=1, id=w}.
- Tag pipeline:
  - Depth LUT_LAT+1 registers (valid plus $clog2(NUM_REQ)-bit id each), so the tag aligns with lut_sin/lut_cos.
  - When the last stage is valid at an edge, the slice id of sin_out/cos_out <= lut_sin/lut_cos.
  - done[id] is high for exactly the following cycle.
- Latency:
  - gnt in cycle t -> lut_phase valid in t+1 -> LUT data valid in t+1+LUT_LAT -> done and new result in t+2+LUT_LAT.
  - With LUT_LAT=1, done arrives in t+3.
- Handshake:
  - Requester holds phase stable while req is high and gnt is low; phase is sampled only in the grant cycle.
  - If req stays high after gnt, it is a new request and is arbitrated again.
- Throughput:
  - Fully pipelined, one lookup per cycle.
  - Multiple lookups from the same requester may be in flight; results retire in issue order.
- Fairness: with all requests held high, grants cycle 0,1,2,3,0,… and no requester waits more than NUM_REQ-1 cycles.
- Result registers: sin_out/cos_out slices hold their value until the next done for that index; other slices are never disturbed.
- idle = (req==0) && no valid tag stage; combinational.
- Phase is passed through unmodified; wrap 1023->0 is the LUT's concern.
- Results are stored verbatim, with no sign extension or scaling.
- Reset mid-operation:
  - All in-flight tags are discarded; no done pulse follows reset.
  - Results are cleared to 0.
  - The first grant after reset goes to the lowest-indexed requester with req set.
- A grant and a retirement in the same cycle are independent and both occur.
- A retirement for index i coinciding with a new gnt[i] is legal: the old result lands, and the new one lands later.

Test Plan:
- Reset check: assert reset 2 cycles -> gnt=0, done=0, idle=1, lut_phase=0, all outputs 0; a LUT model returns sin=phase, cos=~phase.
- Single lookup: req[2]=1 with phase 256 for one cycle:
  - gnt=4'b0100 that cycle.
  - lut_phase=256 at t+1.
  - done=4'b0100 at t+3, sin_out[2] holding the model value for 256; other slices 0.
- Simultaneous: req=4'b1111 held, phases 0/100/512/1023 -> grants 0,1,2,3,0 on consecutive cycles; each done three cycles after its gnt; results match per index.
- Fairness: after a grant to 1, request 0 and 3 together -> 3 is granted before 0; pointer wrap is verified.
- Streaming: req[0] held for 8 cycles with phase incrementing each gnt -> 8 consecutive done[0] pulses with in-order results and idle=0 throughout.
- Reset mid-flight: assert reset 1 cycle after a gnt -> no done pulse afterwards, results 0, rr=0; a new req=4'b1010 grants 1 first.

Source files
------------

// File: rtl/trig_arbiter.sv
// Round-robin arbiter sharing one sin_cos lookup between NUM_REQ requesters,
// with a tag pipeline that routes each LUT result back to its requester.
module trig_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PHASE_W = 10,
  parameter int VAL_W   = 18,
  parameter int LUT_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*PHASE_W-1:0] phase,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [PHASE_W-1:0]         lut_phase,
  input  logic [VAL_W-1:0]           lut_sin,
  input  logic [VAL_W-1:0]           lut_cos,
  output logic [NUM_REQ*VAL_W-1:0]   sin_out,
  output logic [NUM_REQ*VAL_W-1:0]   cos_out,
  output logic [NUM_REQ-1:0]         done,
  output logic                       idle
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = LUT_LAT + 1;

  logic [ID_W-1:0]    rr;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    rr_next;
  logic               found;
  logic               grant;
  logic [PHASE_W-1:0] phase_arr [NUM_REQ];
  logic [DEPTH-1:0]   tag_vld;
  logic [ID_W-1:0]    tag_id [DEPTH];
  logic [VAL_W-1:0]   sin_q [NUM_REQ];
  logic [VAL_W-1:0]   cos_q [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign phase_arr[i]                = phase[i*PHASE_W +: PHASE_W];
    assign sin_out[i*VAL_W +: VAL_W]   = sin_q[i];
    assign cos_out[i*VAL_W +: VAL_W]   = cos_q[i];
  end

  // Search from rr upward with wrap; the first requester found wins.
  always_comb begin
    logic [ID_W:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  assign grant   = found & ~reset;
  assign rr_next = (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);

  always_comb begin
    gnt = '0;
    if (grant) gnt[win] = 1'b1;
  end

  assign idle = (req == '0) && (tag_vld == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr        <= '0;
      lut_phase <= '0;
      tag_vld   <= '0;
      done      <= '0;
      for (int k = 0; k < DEPTH; k++) tag_id[k] <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        sin_q[i] <= '0;
        cos_q[i] <= '0;
      end
    end else begin
      done       <= '0;
      tag_vld[0] <= grant;
      tag_id[0]  <= win;
      for (int k = 1; k < DEPTH; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
      if (grant) begin
        lut_phase <= phase_arr[win];
        rr        <= rr_next;
      end
      // The last tag stage lines up with the LUT output for that lookup.
      if (tag_vld[DEPTH-1]) begin
        sin_q[tag_id[DEPTH-1]] <= lut_sin;
        cos_q[tag_id[DEPTH-1]] <= lut_cos;
        done[tag_id[DEPTH-1]]  <= 1'b1;
      end
    end
  end

endmodule
